// File: rtl/data_pack.sv
// rtl/data_pack.sv - packs narrow values LSB-first into wide tagged words behind a small output FIFO
module data_pack #(
    parameter int DATA_BITWIDTH = 5,
    parameter int INPUT_SIZE    = 7,
    parameter int FIFO_DEPTH    = 4,
    parameter int DATA_SIZE     = 2**DATA_BITWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [INPUT_SIZE-1:0] data_in,
    input  logic                  sop_in,
    input  logic                  eop_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_SIZE-1:0]  data_out,
    output logic                  sop_out,
    output logic                  eop_out,
    output logic                  overflow
);

    // Accumulator must hold a not-yet-full word plus one more value.
    localparam int ACC_W = DATA_SIZE + INPUT_SIZE;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_SIZE + 2;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [INPUT_SIZE-1:0] rem_q, rem_d;
    logic                  first_q, first_d;

    logic                  wr_en;
    logic                  wr_sop;
    logic                  wr_eop;
    logic [DATA_SIZE-1:0]  wr_data;

    logic                  take;
    logic                  restart;
    logic                  in_flush;
    logic                  first_now;
    logic [ACC_W-1:0]      base_acc;
    logic [CNT_W-1:0]      base_cnt;
    logic [ACC_W-1:0]      sum_acc;
    logic [CNT_W-1:0]      sum_cnt;

    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  rd_fire;
    logic                  push;
    logic [ENT_W-1:0]      head;

    // Packing FSM: decides which values are absorbed and which word (if any) is written this cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        first_d   = first_q;
        wr_en     = 1'b0;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        wr_data   = '0;
        take      = 1'b0;
        restart   = 1'b0;
        in_flush  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in && sop_in) begin
                    take    = 1'b1;
                    restart = 1'b1;
                end
            end
            PACK: begin
                if (valid_in) begin
                    take    = 1'b1;
                    restart = sop_in;
                end
            end
            FLUSH: begin
                // Residual bits of the previous packet go out now; a new sop value may start alongside.
                in_flush = 1'b1;
                wr_en    = 1'b1;
                wr_eop   = 1'b1;
                wr_data  = {{(DATA_SIZE-INPUT_SIZE){1'b0}}, rem_q};
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = IDLE;
                if (valid_in && sop_in) begin
                    take    = 1'b1;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sop value always starts from an empty accumulator, dropping any partial word.
        base_acc  = restart ? '0 : acc_q;
        base_cnt  = restart ? '0 : cnt_q;
        first_now = restart ? 1'b1 : first_q;
        sum_acc   = base_acc | ({{DATA_SIZE{1'b0}}, data_in} << base_cnt);
        sum_cnt   = base_cnt + CNT_W'(INPUT_SIZE);

        if (take) begin
            state_d = PACK;
            if (eop_in && !in_flush) begin
                wr_en   = 1'b1;
                wr_sop  = first_now;
                wr_data = sum_acc[DATA_SIZE-1:0];
                first_d = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                if (sum_cnt > CNT_W'(DATA_SIZE)) begin
                    rem_d   = sum_acc[ACC_W-1:DATA_SIZE];
                    state_d = FLUSH;
                end else begin
                    wr_eop  = 1'b1;
                    state_d = sop_in ? PACK : IDLE;
                end
            end else if (sum_cnt >= CNT_W'(DATA_SIZE)) begin
                wr_en   = 1'b1;
                wr_sop  = first_now;
                wr_data = sum_acc[DATA_SIZE-1:0];
                first_d = 1'b0;
                acc_d   = sum_acc >> DATA_SIZE;
                cnt_d   = sum_cnt - CNT_W'(DATA_SIZE);
            end else begin
                acc_d   = sum_acc;
                cnt_d   = sum_cnt;
                first_d = first_now;
            end
        end
    end

    // Output FIFO bookkeeping: a write into a full FIFO only succeeds if the head leaves the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
        rd_fire    = !fifo_empty && ready_in;
        push       = wr_en && (!fifo_full || rd_fire);
        overflow_d = overflow_q | (wr_en && fifo_full && !rd_fire);
        wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = rd_fire ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {wr_sop, wr_eop, wr_data};
        end
    end

    // Head of the FIFO, forced to zero whenever nothing is presented.
    always_comb begin
        head      = mem_q[rd_ptr_q[AW-1:0]];
        valid_out = !fifo_empty;
        sop_out   = valid_out & head[ENT_W-1];
        eop_out   = valid_out & head[ENT_W-2];
        data_out  = valid_out ? head[DATA_SIZE-1:0] : '0;
        overflow  = overflow_q;
    end

    // State, accumulator and FIFO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_pack.sv
// tb/tb_data_pack.sv - self-checking bench for data_pack against a packet-level bit-queue model
module tb_data_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [6:0]  data_in;
    logic        sop_in;
    logic        eop_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        sop_out;
    logic        eop_out;
    logic        overflow;

    int          n_vec = 0;
    int          n_err = 0;

    logic [33:0] exp_q[$];
    logic [33:0] got[$];
    bit          bq[$];
    bit          in_pkt = 0;
    bit          first = 0;

    data_pack dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic emit(input bit last);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32 && bq.size() > 0; i++) w[i] = bq.pop_front();
        exp_q.push_back({first, last, w});
        first = 0;
    endtask

    // Reference: a packet is a bit stream, cut into 32-bit words as soon as they fill; eop flushes the rest.
    task automatic model_in(input logic v, input logic [6:0] d, input logic s, input logic e);
        if (!v) return;
        if (s) begin
            bq.delete();
            in_pkt = 1;
            first  = 1;
        end else if (!in_pkt) begin
            return;
        end
        for (int i = 0; i < 7; i++) bq.push_back(d[i]);
        if (e) begin
            while (bq.size() > 0) emit(bq.size() <= 32);
            in_pkt = 0;
        end else begin
            while (bq.size() >= 32) emit(1'b0);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        bq.delete();
        in_pkt = 0;
        first  = 0;
    endtask

    // One clock: drive inputs, check any word handed over this cycle, advance the model.
    task automatic step(input logic v, input logic [6:0] d, input logic s, input logic e, input logic r);
        logic [33:0] obs;
        logic [63:0] ex;
        valid_in = v;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        ready_in = r;
        if (valid_out && r) begin
            obs = {sop_out, eop_out, data_out};
            got.push_back(obs);
            ex = (exp_q.size() > 0) ? {30'd0, exp_q.pop_front()} : 64'hBAD0_0000_0000_0000;
            chk("word", {30'd0, obs}, ex);
        end
        model_in(v, d, s, e);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step(0, 7'h00, 0, 0, 1);
            n++;
        end
        step(0, 7'h00, 0, 0, 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, valid_out, 0);
    endtask

    initial begin
        int          b;
        logic [33:0] g;
        logic        v, s, e, r;
        logic [6:0]  d;

        rst = 1'b0;
        valid_in = 0; data_in = 0; sop_in = 0; eop_in = 0; ready_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        @(negedge clk);

        // 32 values 1..32: exactly 7 words, last completes on the eop value itself
        b = got.size();
        for (int i = 1; i <= 32; i++) begin
            step(1, 7'(i), i == 1, i == 32, 1);
            if (i == 4) chk("lat_before", valid_out, 0);
            if (i == 5) chk("lat_after", valid_out, 1);
        end
        drain("seq32");
        chk("seq32_count", got.size() - b, 7);
        g = got[b];
        chk("seq32_w0_sop", g[33], 1);
        chk("seq32_w0_v0", g[6:0], 7'h01);
        chk("seq32_w0_v1", g[13:7], 7'h02);
        g = got[b + 6];
        chk("seq32_w6_eop", g[32], 1);

        // 35-bit packet needs FLUSH; next packet's sop arrives in the FLUSH cycle
        b = got.size();
        for (int i = 0; i < 5; i++) step(1, 7'h7F, i == 0, i == 4, 1);
        step(1, 7'h11, 1, 0, 1);
        step(1, 7'h22, 0, 0, 1);
        step(1, 7'h33, 0, 1, 1);
        drain("flush");
        chk("flush_count", got.size() - b, 3);
        chk("flush_w0", got[b], {1'b1, 1'b0, 32'hFFFF_FFFF});
        chk("flush_w1", got[b + 1], {1'b0, 1'b1, 32'h0000_0007});
        chk("flush_w2", got[b + 2], {1'b1, 1'b1, 32'h000C_D111});

        // 21-bit packet: single word tagged both sop and eop
        b = got.size();
        for (int i = 0; i < 3; i++) step(1, 7'h7F, i == 0, i == 2, 1);
        drain("short");
        chk("short_w0", got[b], {1'b1, 1'b1, 32'h001F_FFFF});

        // values outside a packet are discarded; sop mid-packet aborts the old one
        b = got.size();
        for (int i = 0; i < 6; i++) step(1, 7'(i + 40), 0, 0, 1);
        chk("stray_words", got.size() - b, 0);
        chk("stray_valid", valid_out, 0);
        step(1, 7'h05, 1, 0, 1);
        step(1, 7'h06, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 7'(i + 16), i == 0, i == 5, 1);
        drain("abort");
        chk("abort_count", got.size() - b, 2);

        // ready low through five words: four kept in order, fifth dropped, overflow sticky
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++) step(1, 7'(p + 1), i == 0, i == 2, 0);
            if (p == 3) chk("ovf_before", overflow, 0);
        end
        void'(exp_q.pop_back());
        chk("ovf_set", overflow, 1);
        drain("ovf");
        chk("ovf_sticky", overflow, 1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        chk("ovf_cleared", overflow, 0);
        @(negedge clk);

        // asynchronous reset mid-packet with a word waiting in the FIFO
        for (int i = 0; i < 3; i++) step(1, 7'h2A, i == 0, i == 2, 0);
        for (int i = 0; i < 3; i++) step(1, 7'h15, i == 0, 0, 0);
        chk("arst_pre_valid", valid_out, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", valid_out, 0);
        chk("arst_data", data_out, 0);
        chk("arst_sop", sop_out, 0);
        chk("arst_eop", eop_out, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        b = got.size();
        for (int i = 0; i < 6; i++) step(1, 7'h15, 0, i == 5, 1);
        chk("arst_no_words", got.size() - b, 0);
        for (int i = 0; i < 4; i++) step(1, 7'(i + 100), i == 0, i == 3, 1);
        drain("arst");
        chk("arst_count", got.size() - b, 1);

        // randomized traffic with gaps, aborts, stray values and light backpressure
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 15) == 0);
            e = !s && ($urandom_range(0, 7) == 0);
            d = 7'($urandom_range(0, 127));
            r = ($urandom_range(0, 3) != 0);
            step(v, d, s, e, r);
        end
        step(1, 7'h01, 0, 1, 1);
        drain("rand");
        chk("rand_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
